// File: rtl/z80_bus_pkg.sv
// Shared types and bus-cycle decode for the tv80s slave-side bus responder.
package z80_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, HOLD} resp_state_t;

  typedef enum logic [2:0] {NONE, MEMRD, MEMWR, IORD, IOWR, INTA, REFRESH} cyc_t;

  localparam int unsigned IO_PORTS = 256;

  // Both MREQ and IORQ low is illegal and decodes to NONE; refresh wins over RD/WR.
  function automatic cyc_t cyc_decode(input logic m1_n, input logic mreq_n,
                                      input logic iorq_n, input logic rd_n,
                                      input logic wr_n, input logic rfsh_n);
    cyc_t c;
    c = NONE;
    if (!mreq_n && iorq_n) begin
      if (!rfsh_n)    c = REFRESH;
      else if (!rd_n) c = MEMRD;
      else if (!wr_n) c = MEMWR;
    end else if (!iorq_n && mreq_n) begin
      if (!m1_n)      c = INTA;
      else if (!rd_n) c = IORD;
      else if (!wr_n) c = IOWR;
    end
    return c;
  endfunction

  function automatic logic cyc_is_read(input cyc_t c);
    return (c == MEMRD) || (c == IORD);
  endfunction

endpackage

// File: rtl/z80_bus_responder_wait.sv
// Wait-request generator: loads WAIT_STATES on a read access and holds o_wait_n low
// for exactly that many clocks. Only instantiated when Z80_RESP_WAIT_EN is defined.
module z80_wait_gen
  import z80_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_clear,
  output logic o_wait_n,
  output logic o_last
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_wait_n;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_cnt    <= '0;
      r_wait_n <= 1'b1;
    end else if (i_load && (WAIT_STATES > 0)) begin
      r_cnt    <= CW'(WAIT_STATES);
      r_wait_n <= 1'b0;
    end else if (r_cnt > CW'(1)) begin
      r_cnt    <= r_cnt - 1'b1;
    end else begin
      r_cnt    <= '0;
      r_wait_n <= 1'b1;
    end
  end

  assign o_wait_n = r_wait_n;
  assign o_last   = (r_cnt <= CW'(1));

endmodule

// File: rtl/z80_bus_responder.sv
// Memory + I/O slave for the tv80s bus with backdoor RAM preload.
// Wait states are generated only when Z80_RESP_WAIT_EN is defined.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  INT_VEC     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data
);

`ifdef Z80_RESP_WAIT_EN
  localparam int unsigned WS_EFF = WAIT_STATES;
`else
  // Parameter kept for drop-in compatibility; waits are forced off in this build.
  localparam int unsigned WS_EFF = WAIT_STATES * 0;
`endif

  resp_state_t r_state, w_state_nxt;
  cyc_t        w_cyc, r_cyc;
  logic        w_start, w_illegal, w_rd;
  logic        w_wait_n, w_wait_last;
  logic [7:0]  r_cpu_di;
  logic [7:0]  r_mem [2**MEM_AW];
  logic [7:0]  r_io  [IO_PORTS];

  logic [MEM_AW-1:0] w_maddr, w_laddr;
  assign w_maddr = A[MEM_AW-1:0];
  assign w_laddr = ld_addr[MEM_AW-1:0];

  assign w_cyc     = cyc_decode(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
  assign w_illegal = !mreq_n && !iorq_n;
  assign w_rd      = cyc_is_read(w_cyc);

  // A strobe still asserted in HOLD is the same cycle unless its type changed
  // (e.g. M1 opcode read followed directly by refresh).
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cyc != NONE) begin
          w_state_nxt = ACCESS;
          w_start     = 1'b1;
        end
      end
      ACCESS: w_state_nxt = (cyc_is_read(r_cyc) && (WS_EFF != 0)) ? WAIT : HOLD;
      WAIT: begin
        if (w_wait_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_cyc != NONE && w_cyc != r_cyc) begin
          w_state_nxt = ACCESS;
          w_start     = 1'b1;
        end else if (mreq_n && iorq_n) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_illegal) begin
      w_state_nxt = IDLE;
      w_start     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cyc    <= NONE;
      r_cpu_di <= '0;
      for (int unsigned i = 0; i < IO_PORTS; i++) r_io[8'(i)] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cyc <= w_cyc;
        case (w_cyc)
          MEMRD:   r_cpu_di     <= r_mem[w_maddr];
          IORD:    r_cpu_di     <= r_io[A[7:0]];
          INTA:    r_cpu_di     <= INT_VEC;
          IOWR:    r_io[A[7:0]] <= cpu_do;
          default: ;
        endcase
      end
    end
  end

  // Backdoor is written last so it wins a same-address collision; it ignores reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_start && (w_cyc == MEMWR)) r_mem[w_maddr] <= cpu_do;
    if (ld_we) r_mem[w_laddr] <= ld_data;
  end

`ifdef Z80_RESP_WAIT_EN
  z80_wait_gen #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_gen (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_load  (w_start && w_rd),
    .i_clear (w_illegal),
    .o_wait_n(w_wait_n),
    .o_last  (w_wait_last)
  );
`else
  assign w_wait_n    = 1'b1;
  assign w_wait_last = 1'b1;
`endif

  assign cpu_di = r_cpu_di;
  assign wait_n = w_wait_n;

endmodule
